subdiv_top: RTL and testbench
=============================

Name: subdiv_top

Overview:
- Top-level compute block of the subdivision-surface engine: one pass of Catmull-Clark face-point generation over a quad mesh held in an on-chip word memory.
- For each quad face it fetches four vertex indices, reads the four vertices, averages them per coordinate and writes the face point to an output region.
- A host port loads the mesh and reads back results while the block is idle; `start`/`busy` form the job handshake.

Parameters:
- ADDR_WIDTH, 11, memory address width; 2^ADDR_WIDTH words.
- DATA_WIDTH, 48, memory word width.
- FACE_BASE, 1024, word address of face 0.
- OUT_BASE, 1536, word address of face point 0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  job request, level-sampled in IDLE, re-armed by deassertion.
- busy  output  1  high while a job runs.
- num_faces  input  ADDR_WIDTH-2  face count F, sampled when a job is accepted.
- mem_we  input  1  host write enable, honoured only when busy=0.
- mem_addr  input  ADDR_WIDTH  host address.
- mem_wdata  input  DATA_WIDTH  host write data.
- mem_rdata  output  DATA_WIDTH  host read data, 1-cycle latency.

Behaviour:
- Memory: single-port synchronous RAM, 2^ADDR_WIDTH x DATA_WIDTH; read data valid the cycle after the address; contents not reset.
- Vertex word at address i (vertex i): x=[15:0], y=[31:16], z=[47:32], each 16-bit two's complement.
- Face word at FACE_BASE+f: v0=[10:0], v1=[21:11], v2=[32:22], v3=[43:33]; bits [47:44] ignored.
- Output word at OUT_BASE+f uses the vertex format.
- Face indices are unchecked; any address is read as a vertex.
- Arithmetic:
  - Each coordinate is summed in 18-bit signed.
  - Result = sum >>> 2 (arithmetic shift, floor toward -inf), truncated to 16 bits; no saturation needed.
- Reset (rst_n=0 at a clock edge):
  - busy=0, mem_rdata=0, FSM to IDLE, armed=1, accumulators cleared.
  - Reset mid-job aborts immediately; face points already written remain.
- Start and re-arm:
  - In IDLE, start=1 with armed=1 accepts a job: F is latched, armed is cleared, busy=1 from the next cycle.
  - armed sets again only when start=0 is sampled.
  - Holding start high after a job therefore does not retrigger; busy falls and stays low.
- States: IDLE, INIT, FACE_RD, FACE_LAT, V1, V2, V3, ACC3, WRITE.
  - INIT: face counter f=0; if F=0 go to IDLE, else FACE_RD.
  - FACE_RD: issue FACE_BASE+f.
  - FACE_LAT: latch indices, issue v0.
  - V1: issue v1, load acc with v0.
  - V2: issue v2, add v1.
  - V3: issue v3, add v2.
  - ACC3: add v3.
  - WRITE: write the averaged word to OUT_BASE+f, f++; go to FACE_RD if f<F, else IDLE.
- Timing: 7 cycles per face; busy is high for exactly 1+7*F cycles.
- busy is a registered output: high in every non-IDLE state.
- Host access:
  - While busy=0, mem_we writes mem_wdata to mem_addr, and reads return mem[mem_addr] one cycle later.
  - While busy=1, host writes are dropped and mem_rdata=0.
  - A start accepted in the same cycle as a host write: the write is performed, then the job starts.
- Overlapping regions: a face point written to an address later read as a vertex or face by the same job uses the new value (no snapshot).

Test Plan:
- Reset with start=0 → busy=0, mem_rdata=0; after reset, start held 1 → busy rises next cycle.
- Load vertices 0..3 = (0,0,0), (4,0,0), (4,4,0), (0,4,0); face0 = {0,1,2,3}; F=1; pulse start → busy high exactly 8 cycles; read OUT_BASE → (2,2,0).
- Negative floor: vertices (-1,-1,-1) x3 and (0,0,0); F=1 → output (-1,-1,-1) (sum −3 >>> 2 = −1); extremes 4x(-32768) → −32768 with no overflow.
- F=3 with distinct faces → busy high 22 cycles; OUT_BASE..OUT_BASE+2 correct; OUT_BASE+3 unchanged.
- F=0 → busy high 1 cycle; memory unchanged; start held high after completion → busy stays 0 until start drops and re-rises.
- Host write attempted during busy → memory unchanged, mem_rdata=0; rst_n=0 mid-job → busy=0 next cycle, earlier outputs intact, later outputs unwritten.

Source files
------------

// File: rtl/subdiv_top.sv
// subdiv_top: one Catmull-Clark face-point pass over a quad mesh in on-chip RAM.
//
// For each face f in [0, F) the engine reads the face word at FACE_BASE+f,
// reads its four vertices, averages x/y/z independently (floor of sum/4) and
// writes the result to OUT_BASE+f. Every face takes 7 cycles, plus 1 INIT
// cycle per job.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      job request; one job per assertion (re-armed when start=0)
//   busy       high while a job runs (registered)
//   num_faces  face count F, latched when a job is accepted
//   mem_we     host write enable, honoured only while idle
//   mem_addr   host word address
//   mem_wdata  host write data
//   mem_rdata  host read data, 1-cycle latency, zero while busy
module subdiv_top #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 48,
    parameter int FACE_BASE  = 1024,
    parameter int OUT_BASE   = 1536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    input  logic [ADDR_WIDTH-3:0] num_faces,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int FW = ADDR_WIDTH - 2;  // face counter width
    localparam int IW = 11;              // vertex index field width
    localparam int CW = 16;              // coordinate width
    localparam int SW = 18;              // sum width: 4 x 16-bit cannot overflow

    localparam logic [ADDR_WIDTH-1:0] FACE_A = ADDR_WIDTH'(FACE_BASE);
    localparam logic [ADDR_WIDTH-1:0] OUT_A  = ADDR_WIDTH'(OUT_BASE);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_FACE_RD, S_FACE_LAT, S_V1, S_V2, S_V3, S_ACC3, S_WRITE
    } state_t;

    // Sign-extend one coordinate into the accumulator width.
    function automatic logic signed [SW-1:0] sext(input logic [CW-1:0] c);
        return {{(SW-CW){c[CW-1]}}, c};
    endfunction

    // Average of four: arithmetic shift floors toward -inf; the result always
    // fits back into 16 bits, so plain truncation suffices.
    function automatic logic [CW-1:0] avg4(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] q;
        q = s >>> 2;
        return q[CW-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    state_t                 state, state_nxt;
    logic                   armed;
    logic                   accept;
    logic                   host_rd_vld;
    logic [FW-1:0]          faces_q;
    logic [FW-1:0]          face_cnt;
    logic [FW:0]            cnt_inc;
    logic                   last_face;
    logic [ADDR_WIDTH-1:0]  idx1, idx2, idx3;
    logic signed [SW-1:0]   acc_x, acc_y, acc_z;
    logic [DATA_WIDTH-1:0]  rd_q;

    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic                   ram_we;
    logic [DATA_WIDTH-1:0]  ram_wdata;

    assign accept    = (state == S_IDLE) && start && armed;
    assign cnt_inc   = {1'b0, face_cnt} + 1'b1;
    assign last_face = (cnt_inc >= {1'b0, faces_q});

    // ---- next state and RAM port arbitration ----
    always_comb begin
        state_nxt = state;
        ram_addr  = mem_addr;
        ram_we    = 1'b0;
        ram_wdata = mem_wdata;
        case (state)
            S_IDLE: begin
                // A host write coinciding with an accepted start still lands.
                ram_we = mem_we;
                if (accept) state_nxt = S_INIT;
            end
            S_INIT:     state_nxt = (faces_q == '0) ? S_IDLE : S_FACE_RD;
            S_FACE_RD: begin
                ram_addr  = FACE_A + ADDR_WIDTH'(face_cnt);
                state_nxt = S_FACE_LAT;
            end
            S_FACE_LAT: begin
                // v0 goes straight from the read data; v1..v3 are latched.
                ram_addr  = ADDR_WIDTH'(rd_q[IW-1:0]);
                state_nxt = S_V1;
            end
            S_V1: begin
                ram_addr  = idx1;
                state_nxt = S_V2;
            end
            S_V2: begin
                ram_addr  = idx2;
                state_nxt = S_V3;
            end
            S_V3: begin
                ram_addr  = idx3;
                state_nxt = S_ACC3;
            end
            S_ACC3:     state_nxt = S_WRITE;
            S_WRITE: begin
                ram_addr  = OUT_A + ADDR_WIDTH'(face_cnt);
                ram_we    = 1'b1;
                ram_wdata = DATA_WIDTH'({avg4(acc_z), avg4(acc_y), avg4(acc_x)});
                state_nxt = last_face ? S_IDLE : S_FACE_RD;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // ---- control registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            armed       <= 1'b1;
            host_rd_vld <= 1'b0;
            faces_q     <= '0;
            face_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != S_IDLE);
            host_rd_vld <= (state == S_IDLE) && !accept;
            if (accept) begin
                armed   <= 1'b0;
                faces_q <= num_faces;
            end else if (!start) begin
                armed   <= 1'b1;
            end
            if (state == S_INIT)  face_cnt <= '0;
            if (state == S_WRITE) face_cnt <= cnt_inc[FW-1:0];
        end
    end

    // ---- RAM: single port, read-before-write, writes blocked during reset ----
    always_ff @(posedge clk) begin
        if (ram_we && rst_n) mem[ram_addr] <= ram_wdata;
        rd_q <= mem[ram_addr];
    end

    assign mem_rdata = host_rd_vld ? rd_q : '0;

    // ---- face index latch ----
    always_ff @(posedge clk) begin
        if (state == S_FACE_LAT) begin
            idx1 <= ADDR_WIDTH'(rd_q[2*IW-1:IW]);
            idx2 <= ADDR_WIDTH'(rd_q[3*IW-1:2*IW]);
            idx3 <= ADDR_WIDTH'(rd_q[4*IW-1:3*IW]);
        end
    end

    // ---- accumulate: rd_q holds the vertex issued one state earlier ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_x <= '0;
            acc_y <= '0;
            acc_z <= '0;
        end else begin
            case (state)
                S_V1: begin
                    acc_x <= sext(rd_q[CW-1:0]);
                    acc_y <= sext(rd_q[2*CW-1:CW]);
                    acc_z <= sext(rd_q[3*CW-1:2*CW]);
                end
                S_V2, S_V3, S_ACC3: begin
                    acc_x <= acc_x + sext(rd_q[CW-1:0]);
                    acc_y <= acc_y + sext(rd_q[2*CW-1:CW]);
                    acc_z <= acc_z + sext(rd_q[3*CW-1:2*CW]);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subdiv_top.sv
// Testbench for subdiv_top: scoreboard of expected host read data and of
// expected busy pulse lengths, checked by independent monitor processes.
module tb_subdiv_top;

    localparam int AW = 11;
    localparam int DW = 48;
    localparam int FB = 1024;
    localparam int OB = 1536;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic [AW-3:0] num_faces;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] rd_exp_q[$];
    string         rd_name_q[$];
    int            busy_exp_q[$];
    logic          rd_req = 1'b0;
    logic          rd_vld_d = 1'b0;
    int            busy_cnt = 0;

    subdiv_top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FACE_BASE(FB), .OUT_BASE(OB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .num_faces (num_faces),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] vtx(input int x, input int y, input int z);
        return {16'(z), 16'(y), 16'(x)};
    endfunction

    function automatic logic [DW-1:0] face(input int a, input int b, input int c, input int d);
        return {4'h0, 11'(d), 11'(c), 11'(b), 11'(a)};
    endfunction

    // Read-data monitor: one response per request, one cycle later.
    always @(posedge clk) rd_vld_d <= rd_req;

    always @(negedge clk) begin
        if (rd_vld_d) begin
            if (rd_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got %h expected no read", mem_rdata);
            end else begin
                check(rd_name_q.pop_front(), mem_rdata, rd_exp_q.pop_front());
            end
        end
    end

    // Busy monitor: measures each busy pulse and compares against expectations.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt > 0) begin
            if (busy_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL busy_unexpected: got pulse of %0d expected none", busy_cnt);
            end else begin
                check("busy_len", DW'(busy_cnt), DW'(busy_exp_q.pop_front()));
            end
            busy_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        mem_we    = 1'b1;
        mem_addr  = AW'(a);
        mem_wdata = d;
        tick();
        mem_we    = 1'b0;
    endtask

    task automatic rd(input string name, input int a, input logic [DW-1:0] exp);
        mem_addr = AW'(a);
        rd_req   = 1'b1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        tick();
        rd_req   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL job_timeout: got busy after %0d cycles expected idle", n);
        end
        tick();
    endtask

    task automatic run_job(input int f, input int exp_len);
        num_faces = (AW-2)'(f);
        busy_exp_q.push_back(exp_len);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; num_faces = '0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        tick(); tick();
        check("reset_busy", DW'(busy), '0);
        check("reset_rdata", mem_rdata, '0);

        // start held high through reset release: fires once, no retrigger
        start = 1'b1;
        busy_exp_q.push_back(1);
        rst_n = 1'b1;
        tick();
        check("start_after_reset", DW'(busy), DW'(1));
        repeat (5) tick();
        check("no_retrigger", DW'(busy), '0);
        start = 1'b0;
        tick();
        start = 1'b1;
        busy_exp_q.push_back(1);
        tick();
        check("rearm_start", DW'(busy), DW'(1));
        start = 1'b0;
        tick(); tick();

        // mesh load
        wr(0, vtx(0, 0, 0));
        wr(1, vtx(4, 0, 0));
        wr(2, vtx(4, 4, 0));
        wr(3, vtx(0, 4, 0));
        wr(4, vtx(-1, -1, -1));
        wr(5, vtx(-1, -1, -1));
        wr(6, vtx(-1, -1, -1));
        wr(7, vtx(0, 0, 0));
        wr(8, vtx(-32768, 32767, -32768));
        wr(FB, face(0, 1, 2, 3));
        wr(OB, 48'h1234_5678_9abc);

        // F=0 leaves memory alone
        run_job(0, 1);
        rd("f0_out_unchanged", OB, 48'h1234_5678_9abc);

        // single square face
        run_job(1, 8);
        rd("square_avg", OB, vtx(2, 2, 0));

        // negative floor
        wr(FB, face(4, 5, 6, 7));
        run_job(1, 8);
        rd("neg_floor", OB, vtx(-1, -1, -1));

        // extremes, repeated index
        wr(FB, face(8, 8, 8, 8));
        run_job(1, 8);
        rd("extremes", OB, vtx(-32768, 32767, -32768));

        // three faces, word past the last one untouched
        wr(FB,     face(0, 1, 2, 3));
        wr(FB + 1, face(4, 5, 6, 7));
        wr(FB + 2, face(8, 0, 1, 2));
        wr(OB + 3, 48'hcafe_f00d_beef);
        run_job(3, 22);
        rd("f3_out0", OB,     vtx(2, 2, 0));
        rd("f3_out1", OB + 1, vtx(-1, -1, -1));
        rd("f3_out2", OB + 2, vtx(-8190, 8192, -8192));
        rd("f3_out3_unchanged", OB + 3, 48'hcafe_f00d_beef);

        // write with start in same cycle lands; writes during busy dropped
        num_faces = 9'd3;
        busy_exp_q.push_back(22);
        start = 1'b1; mem_we = 1'b1; mem_addr = 11'd12; mem_wdata = vtx(7, 8, 9);
        tick();
        start = 1'b0; mem_we = 1'b0;
        tick();
        wr(0, vtx(100, 100, 100));
        rd("busy_rdata_zero", FB, '0);
        wait_idle(200);
        rd("busy_write_dropped", 0, vtx(0, 0, 0));
        rd("start_cycle_write", 12, vtx(7, 8, 9));
        rd("job_after_drop", OB, vtx(2, 2, 0));

        // reset mid-job: face 0 written, later faces untouched
        wr(OB,     48'h1111_1111_1111);
        wr(OB + 1, 48'h2222_2222_2222);
        wr(OB + 2, 48'h3333_3333_3333);
        num_faces = 9'd3;
        busy_exp_q.push_back(11);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        check("busy_after_abort", DW'(busy), '0);
        rst_n = 1'b1;
        tick();
        rd("abort_out0", OB,     vtx(2, 2, 0));
        rd("abort_out1", OB + 1, 48'h2222_2222_2222);
        rd("abort_out2", OB + 2, 48'h3333_3333_3333);
        tick(); tick();

        check("rd_queue_drained", DW'(rd_exp_q.size()), '0);
        check("busy_queue_drained", DW'(busy_exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
